// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with one outstanding request and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stallF,
    input  logic        flushD,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] AddrD,
    output logic [31:0] InstD,
    output logic        validD,
    output logic        fetch_busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        deliver;
    logic [31:0] word;

    assign imem_req   = (state_q == ISSUE) && !br_taken;
    assign imem_addr  = pc_q;
    assign fetch_busy = (state_q == WAIT) || (state_q == DROP);
    assign AddrD      = addr_q;
    assign InstD      = inst_q;
    assign validD     = valid_q;

    // Fetch controller: next state, PC, hold buffer and delivery of a fetched word
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        deliver = 1'b0;
        word    = hold_q;
        case (state_q)
            IDLE: begin
                state_d = ISSUE;
                if (br_taken) pc_d = br_target;
            end
            ISSUE: begin
                if (br_taken) pc_d = br_target;
                else state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (br_taken) begin
                        pc_d    = br_target;
                        state_d = ISSUE;
                    end else if (stallF) begin
                        hold_d  = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        deliver = 1'b1;
                        word    = imem_rdata;
                        pc_d    = pc_q + 32'd4;
                        state_d = ISSUE;
                    end
                end else if (br_taken) begin
                    pc_d    = br_target;
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (br_taken) begin
                    pc_d    = br_target;
                    state_d = ISSUE;
                end else if (!stallF) begin
                    deliver = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = ISSUE;
                end
            end
            DROP: begin
                if (br_taken) pc_d = br_target;
                if (imem_rvalid) state_d = ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    // IF/ID register: flush beats stall, stall beats delivery, otherwise a bubble
    always_comb begin
        addr_d  = addr_q;
        inst_d  = NOP_INSTR;
        valid_d = 1'b0;
        if (!flushD && stallF) begin
            inst_d  = inst_q;
            valid_d = valid_q;
        end else if (!flushD && deliver) begin
            addr_d  = pc_q;
            inst_d  = word;
            valid_d = 1'b1;
        end
    end

    // State, PC, hold buffer and IF/ID registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            addr_q  <= '0;
            inst_q  <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven cycle checks of fetch_stage with the bench acting as memory
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stallF = 1'b0;
    logic        flushD = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] AddrD;
    logic [31:0] InstD;
    logic        validD;
    logic        fetch_busy;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        st;
        logic        fl;
        logic        br;
        logic [31:0] tg;
        logic        req;
        logic [31:0] ad;
        logic        bsy;
        logic [31:0] ad_d;
        logic [31:0] in_d;
        logic        vd;
    } vec_t;

    vec_t tbl[28];

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stallF(stallF), .flushD(flushD),
        .br_taken(br_taken), .br_target(br_target),
        .AddrD(AddrD), .InstD(InstD), .validD(validD),
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rv, logic [31:0] rd, logic st, logic fl, logic br, logic [31:0] tg,
                                logic req, logic [31:0] ad, logic bsy,
                                logic [31:0] ad_d, logic [31:0] in_d, logic vd);
        vec_t v;
        v.rv = rv; v.rd = rd; v.st = st; v.fl = fl; v.br = br; v.tg = tg;
        v.req = req; v.ad = ad; v.bsy = bsy; v.ad_d = ad_d; v.in_d = in_d; v.vd = vd;
        return v;
    endfunction

    task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    // one cycle: drive inputs after negedge, check request side, clock, check IF/ID
    task automatic apply(input int step, input vec_t v);
        @(negedge clk);
        imem_rvalid = v.rv; imem_rdata = v.rd; stallF = v.st;
        flushD = v.fl; br_taken = v.br; br_target = v.tg;
        #1;
        check("imem_req", step, {31'b0, imem_req}, {31'b0, v.req});
        check("imem_addr", step, imem_addr, v.ad);
        check("fetch_busy", step, {31'b0, fetch_busy}, {31'b0, v.bsy});
        @(posedge clk);
        #1;
        check("AddrD", step, AddrD, v.ad_d);
        check("InstD", step, InstD, v.in_d);
        check("validD", step, {31'b0, validD}, {31'b0, v.vd});
    endtask

    task automatic check_reset_outputs(input int step);
        check("rst imem_req", step, {31'b0, imem_req}, 32'd0);
        check("rst imem_addr", step, imem_addr, 32'h0);
        check("rst fetch_busy", step, {31'b0, fetch_busy}, 32'd0);
        check("rst AddrD", step, AddrD, 32'h0);
        check("rst InstD", step, InstD, 32'h13);
        check("rst validD", step, {31'b0, validD}, 32'd0);
    endtask

    initial begin
        //            rv rdata         st fl br target         req addr          bsy AddrD         InstD         vD
        tbl[0]  = mk(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h13,       0);
        tbl[1]  = mk(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h13,       0);
        tbl[2]  = mk(1, 32'h00500093, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h00500093, 1);
        tbl[3]  = mk(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h13,       0);
        tbl[4]  = mk(1, 32'h00A00113, 1, 0, 0, 32'h0,        0, 32'h4,        1, 32'h0,        32'h13,       0);
        tbl[5]  = mk(0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h4,        0, 32'h0,        32'h13,       0);
        tbl[6]  = mk(0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h4,        0, 32'h0,        32'h13,       0);
        tbl[7]  = mk(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h4,        0, 32'h4,        32'h00A00113, 1);
        tbl[8]  = mk(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h8,        0, 32'h4,        32'h13,       0);
        tbl[9]  = mk(0, 32'h0,        0, 0, 1, 32'h100,      0, 32'h8,        1, 32'h4,        32'h13,       0);
        tbl[10] = mk(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h100,      1, 32'h4,        32'h13,       0);
        tbl[11] = mk(1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 32'h100,      1, 32'h4,        32'h13,       0);
        tbl[12] = mk(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h100,      0, 32'h4,        32'h13,       0);
        tbl[13] = mk(1, 32'h00100193, 0, 0, 0, 32'h0,        0, 32'h100,      1, 32'h100,      32'h00100193, 1);
        tbl[14] = mk(0, 32'h0,        0, 0, 1, 32'h200,      0, 32'h104,      0, 32'h100,      32'h13,       0);
        tbl[15] = mk(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h200,      0, 32'h100,      32'h13,       0);
        tbl[16] = mk(1, 32'h00208233, 0, 0, 0, 32'h0,        0, 32'h200,      1, 32'h200,      32'h00208233, 1);
        tbl[17] = mk(0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h204,      0, 32'h200,      32'h00208233, 1);
        tbl[18] = mk(0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h204,      1, 32'h200,      32'h13,       0);
        tbl[19] = mk(1, 32'h12345678, 0, 0, 0, 32'h0,        0, 32'h204,      1, 32'h204,      32'h12345678, 1);
        tbl[20] = mk(1, 32'h00000BAD, 0, 0, 0, 32'h0,        1, 32'h208,      0, 32'h204,      32'h13,       0);
        tbl[21] = mk(1, 32'h11111111, 1, 0, 0, 32'h0,        0, 32'h208,      1, 32'h204,      32'h13,       0);
        tbl[22] = mk(0, 32'h0,        1, 0, 1, 32'hFFFFFFFC, 0, 32'h208,      0, 32'h204,      32'h13,       0);
        tbl[23] = mk(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h204,      32'h13,       0);
        tbl[24] = mk(1, 32'h22222222, 0, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h22222222, 1);
        tbl[25] = mk(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 32'hFFFFFFFC, 32'h13,       0);
        tbl[26] = mk(1, 32'h33333333, 0, 0, 1, 32'h300,      0, 32'h0,        1, 32'hFFFFFFFC, 32'h13,       0);
        tbl[27] = mk(0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h300,      0, 32'hFFFFFFFC, 32'h13,       0);

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(-1);
        @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 28; i++) apply(i, tbl[i]);

        // state is WAIT on 0x300; pull reset between clock edges
        #2 rst = 1'b0;
        #1;
        check_reset_outputs(100);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        apply(101, mk(1, 32'hCAFEF00D, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h13, 0));
        apply(102, mk(1, 32'hCAFEF00D, 0, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h13, 0));
        apply(103, mk(1, 32'h00500093, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h00500093, 1));
        apply(104, mk(0, 32'h0,        0, 0, 0, 32'h0, 1, 32'h4, 0, 32'h0, 32'h13, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC, issues one-outstanding-request fetches to instruction memory and absorbs variable memory latency. Accepts stalls, flushes and branch redirects from downstream. Its IF/ID pipeline register produces `AddrD`/`InstD`, which the decode stage consumes and the ID/EX register captures.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request, one-cycle pulse.
- `imem_addr` out 32: fetch address, always equals current PC.
- `imem_rvalid` in 1: response valid, one cycle per request.
- `imem_rdata` in 32: response instruction word.
- `stallF` in 1: hold PC and IF/ID (hazard unit).
- `flushD` in 1: replace IF/ID contents with a bubble.
- `br_taken` in 1: redirect PC, from execute.
- `br_target` in 32: redirect address.
- `AddrD` out 32: PC of the instruction in IF/ID.
- `InstD` out 32: instruction in IF/ID.
- `validD` out 1: IF/ID holds a real instruction.
- `fetch_busy` out 1: request outstanding (WAIT or DROP).

## Operation
- **States:** IDLE, ISSUE, WAIT, HOLD, DROP. Reset state is IDLE.
- **IDLE:** no request; goes to ISSUE next cycle. On `br_taken`, also loads `pc <= br_target`.
- **ISSUE:**
  - `imem_req = 1` and `imem_addr = pc`, then go to WAIT. Requests are issued even while `stallF` is high (prefetch).
  - With `br_taken`: `imem_req` is suppressed, `pc <= br_target`, stay in ISSUE.
- **WAIT:**
  - `imem_rvalid` with `br_taken`: discard the response, `pc <= br_target`, go to ISSUE.
  - `imem_rvalid` with `stallF` (no branch): store `imem_rdata` in the hold buffer, go to HOLD.
  - `imem_rvalid` otherwise: deliver the word to IF/ID, `pc <= pc+4`, go to ISSUE.
  - `br_taken` without `imem_rvalid`: `pc <= br_target`, go to DROP.
- **HOLD:**
  - `br_taken`: discard the buffer, `pc <= br_target`, go to ISSUE.
  - `stallF` low: deliver the buffer to IF/ID, `pc <= pc+4`, go to ISSUE.
- **DROP:**
  - Wait for `imem_rvalid`, discard it, go to ISSUE.
  - `br_taken` in DROP updates `pc <= br_target` and stays in DROP.
- **`imem_rvalid` outside WAIT/DROP** (IDLE, ISSUE, HOLD) is ignored.
- **PC arithmetic:** 32-bit; `pc+4` wraps from 0xFFFF_FFFC to 0x0. `br_target` is taken as-is, with no alignment check.
- **IF/ID update priority, each cycle:**
  1. `flushD`: bubble (`InstD=NOP_INSTR`, `validD=0`, `AddrD` unchanged).
  2. `stallF`: hold all three outputs.
  3. Deliver: `AddrD=pc`, `InstD` = word, `validD=1`.
  4. Otherwise: bubble.
- A delivery cannot coincide with `stallF` (WAIT diverts to HOLD), so no instruction is lost. When `flushD` coincides with a delivery, the delivered word is dropped and PC has still advanced; this is intended, because the upstream control always pairs `flushD` with `br_taken`.
- `fetch_busy = (state==WAIT) || (state==DROP)`.

## Timing
- **Reset values (asserted asynchronously):** `pc=RESET_PC`, state IDLE, `imem_req=0`, `imem_addr=RESET_PC`, `AddrD=0`, `InstD=NOP_INSTR`, `validD=0`, `fetch_busy=0`, hold buffer empty.
- **Reset mid-operation:** the outstanding request is abandoned. A late `imem_rvalid` arriving after release lands in IDLE/ISSUE and is ignored.
- `imem_req` and `imem_addr` are combinational from state, PC and `br_taken`. All other outputs are registered.
- **Latency:** response at cycle T appears on `AddrD`/`InstD` at T+1.
- **Memory latency L** = cycles from `imem_req` to `imem_rvalid`, L ≥ 1. Peak throughput is one instruction per L+1 cycles; L=1 gives one per 2 cycles.
- **First fetch:** `imem_req` appears in the second cycle after reset release.
- **Redirect penalty:** the target request issues at the earliest in the cycle after `br_taken` (from ISSUE/WAIT-with-rvalid/HOLD), or after the stale response drains (DROP).

## Test plan
- **Reset and first fetch:** release reset, L=1, mem[0]=0x00500093 -> `imem_req` pulses with addr 0x0; `AddrD=0x0`, `InstD=0x00500093`, `validD=1` one cycle after rvalid; next request addr 0x4.
- **Stall on response:** `stallF=1` during rvalid of 0x00A00113 and held 3 cycles -> IF/ID unchanged; one cycle after `stallF` falls, `InstD=0x00A00113`; next request addr +4.
- **Redirect while waiting:** L=3, `br_taken` with target 0x100 in the first WAIT cycle -> DROP; stale response discarded and `validD` stays 0; next `imem_req` has addr 0x100.
- **Redirect in ISSUE:** `br_taken` with target 0x200 in an ISSUE cycle -> no `imem_req` that cycle; request with addr 0x200 the next cycle.
- **Flush beats stall:** `flushD=1` and `stallF=1` together -> `InstD=0x00000013`, `validD=0`, `AddrD` unchanged.
- **Async reset mid-WAIT:** drop `rst` between edges -> outputs take reset values immediately; the rvalid arriving after release is ignored and the first request after release has addr `RESET_PC`.
